// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Combinational IF lookup; table and statistics update on MEM commit.
module branch_predictor #(
  parameter  int ENTRIES = 16,
  localparam int IDX     = $clog2(ENTRIES),
  localparam int TAGW    = 30 - IDX
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IFpc,
  output logic        PRtaken,
  output logic [31:0] PRtarget,
  input  logic        MMbranch,
  input  logic        MMEN,
  input  logic [31:0] MMpc,
  input  logic [31:0] MMtarget,
  input  logic        MMtaken,
  input  logic        ABtaken,
  output logic [31:0] branches,
  output logic [31:0] mispredicts
);

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [31:0] branches_q, branches_d;
  logic [31:0] mispredicts_q, mispredicts_d;

  logic [IDX-1:0]  lk_idx, cm_idx;
  logic [TAGW-1:0] lk_tag, cm_tag;
  logic            lk_hit, cm_hit;
  logic            commit;
  logic [1:0]      ctr_d;

  // Byte offset within the word never affects prediction.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{IFpc[1:0], MMpc[1:0]};

  assign lk_idx = IFpc[IDX+1:2];
  assign lk_tag = IFpc[31:IDX+2];
  assign cm_idx = MMpc[IDX+1:2];
  assign cm_tag = MMpc[31:IDX+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign cm_hit = valid_q[cm_idx] && (tag_q[cm_idx] == cm_tag);
  assign commit = MMbranch && MMEN;

  // Fetch-side prediction straight from current table contents.
  always_comb begin
    PRtaken  = lk_hit && ctr_q[lk_idx][1];
    PRtarget = PRtaken ? target_q[lk_idx] : 32'd0;
  end

  // Saturating counter step for the committing entry.
  always_comb begin
    ctr_d = ctr_q[cm_idx];
    if (ABtaken) begin
      if (ctr_d != 2'b11) ctr_d = ctr_d + 2'd1;
    end else begin
      if (ctr_d != 2'b00) ctr_d = ctr_d - 2'd1;
    end
  end

  // Next-state for the statistics counters.
  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (commit) begin
      branches_d = branches_q + 32'd1;
      if (ABtaken != MMtaken)
        mispredicts_d = mispredicts_q + 32'd1;
    end
  end

  // Table update: reset wipes all; a commit touches only its index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (commit) begin
      if (cm_hit) begin
        ctr_q[cm_idx] <= ctr_d;
        if (ABtaken) target_q[cm_idx] <= MMtarget;
      end else if (ABtaken) begin
        valid_q[cm_idx]  <= 1'b1;
        tag_q[cm_idx]    <= cm_tag;
        target_q[cm_idx] <= MMtarget;
        ctr_q[cm_idx]    <= 2'b10;
      end
    end
  end

  // Statistics registers; reset dominates a simultaneous commit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      branches_q    <= 32'd0;
      mispredicts_q <= 32'd0;
    end else begin
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign branches    = branches_q;
  assign mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic
// checked against a table-of-entries reference model.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IFpc;
  logic        PRtaken;
  logic [31:0] PRtarget;
  logic        MMbranch;
  logic        MMEN;
  logic [31:0] MMpc;
  logic [31:0] MMtarget;
  logic        MMtaken;
  logic        ABtaken;
  logic [31:0] branches;
  logic [31:0] mispredicts;

  int passed = 0;
  int total  = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST), .IFpc(IFpc),
    .PRtaken(PRtaken), .PRtarget(PRtarget),
    .MMbranch(MMbranch), .MMEN(MMEN), .MMpc(MMpc),
    .MMtarget(MMtarget), .MMtaken(MMtaken), .ABtaken(ABtaken),
    .branches(branches), .mispredicts(mispredicts)
  );

  always #5 CLK = ~CLK;

  // Reference model: one record per slot, counter as an integer 0..3.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  int unsigned m_target [16];
  int          m_ctr    [16];
  int unsigned m_br;
  int unsigned m_mis;

  function automatic int unsigned slot(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned tagof(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && m_tag[slot(pc)] == tagof(pc);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && m_ctr[slot(pc)] >= 2;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0;
      m_target[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic m_edge();
    int unsigned s;
    if (RST) begin
      m_reset();
    end else if (MMbranch && MMEN) begin
      s = slot(MMpc);
      m_br++;
      if (ABtaken != MMtaken) m_mis++;
      if (m_hit(MMpc)) begin
        if (ABtaken) begin
          if (m_ctr[s] < 3) m_ctr[s]++;
          m_target[s] = MMtarget;
        end else if (m_ctr[s] > 0) begin
          m_ctr[s]--;
        end
      end else if (ABtaken) begin
        m_valid[s] = 1; m_tag[s] = tagof(MMpc);
        m_target[s] = MMtarget; m_ctr[s] = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_model();
    logic [31:0] et;
    et = m_taken(IFpc) ? m_target[slot(IFpc)] : 32'd0;
    chk("PRtaken", {31'd0, PRtaken}, {31'd0, m_taken(IFpc)});
    chk("PRtarget", PRtarget, et);
    chk("branches", branches, m_br);
    chk("mispredicts", mispredicts, m_mis);
  endtask

  task automatic drive(input logic rst, input logic [31:0] ifpc,
                       input logic br, input logic en,
                       input logic [31:0] mpc, input logic [31:0] mtgt,
                       input logic mt, input logic ab);
    RST = rst; IFpc = ifpc; MMbranch = br; MMEN = en;
    MMpc = mpc; MMtarget = mtgt; MMtaken = mt; ABtaken = ab;
  endtask

  // Check outputs for current inputs, then clock once.
  task automatic cyc();
    #1;
    chk_model();
    @(posedge CLK);
    m_edge();
    #1;
  endtask

  task automatic commit(input logic [31:0] ifpc, input logic [31:0] mpc,
                        input logic [31:0] mtgt, input logic mt,
                        input logic ab);
    drive(1'b0, ifpc, 1'b1, 1'b1, mpc, mtgt, mt, ab);
    cyc();
  endtask

  task automatic look(input logic [31:0] ifpc);
    drive(1'b0, ifpc, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk_model();
  endtask

  logic [31:0] br0;
  logic [31:0] rpc;

  initial begin
    m_reset();
    drive(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); m_edge(); #1;

    for (int a = 0; a <= 'h7C; a += 4) begin
      look(a);
      chk("sweep_taken", {31'd0, PRtaken}, 32'd0);
    end
    chk("rst_br", branches, 32'd0);
    chk("rst_mis", mispredicts, 32'd0);

    commit(32'h40, 32'h40, 32'h100, 1'b0, 1'b1);
    look(32'h40);
    chk("alloc_taken", {31'd0, PRtaken}, 32'd1);
    chk("alloc_tgt", PRtarget, 32'h100);
    chk("alloc_br", branches, 32'd1);
    chk("alloc_mis", mispredicts, 32'd1);

    commit(32'h40, 32'h40, 32'h100, 1'b1, 1'b1);
    commit(32'h40, 32'h40, 32'h100, 1'b1, 1'b1);
    commit(32'h40, 32'h40, 32'h100, 1'b1, 1'b0);
    look(32'h40);
    chk("hyst_1nt", {31'd0, PRtaken}, 32'd1);
    commit(32'h40, 32'h40, 32'h100, 1'b1, 1'b0);
    look(32'h40);
    chk("hyst_2nt", {31'd0, PRtaken}, 32'd0);
    commit(32'h40, 32'h40, 32'h100, 1'b0, 1'b0);

    commit(32'h80, 32'h80, 32'h300, 1'b0, 1'b0);
    look(32'h80);
    chk("nt_noalloc", {31'd0, PRtaken}, 32'd0);

    commit(32'h80, 32'h80, 32'h200, 1'b0, 1'b1);
    look(32'h40);
    chk("alias_old", {31'd0, PRtaken}, 32'd0);
    look(32'h80);
    chk("alias_new", PRtarget, 32'h200);

    commit(32'h80, 32'h80, 32'h200, 1'b1, 1'b0);
    look(32'h80);
    chk("bypass_next", {31'd0, PRtaken}, 32'd0);

    br0 = branches;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h80, 1'b1, 1'b0, 32'h44, 32'h500, 1'b0, 1'b1);
      cyc();
    end
    commit(32'h80, 32'h44, 32'h500, 1'b0, 1'b1);
    look(32'h44);
    chk("stall_once", branches - br0, 32'd1);

    drive(1'b1, 32'h44, 1'b1, 1'b1, 32'h48, 32'h600, 1'b0, 1'b1);
    cyc();
    for (int a = 0; a <= 'h7C; a += 4) begin
      look(a);
      chk("rst_commit", {31'd0, PRtaken}, 32'd0);
    end
    chk("rst_commit_br", branches, 32'd0);
    chk("rst_commit_mis", mispredicts, 32'd0);

    for (int n = 0; n < 600; n++) begin
      rpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
          | $urandom_range(0, 3);
      drive($urandom_range(0, 99) == 0, IFpc,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            rpc, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
      IFpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
           | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) IFpc = rpc;
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
